// File: rtl/tape_mem_arbiter.sv
// Two-port round-robin arbiter sharing the single tape memory port between the
// Turing-machine engine (port 0) and a tape scanner/debug reader (port 1).
// Works with both a zero-latency SRAM (ack=1, busy=0) and a multi-cycle DRAM
// controller; aborts a transaction that is not acked within TIMEOUT cycles.
module tape_mem_arbiter #(
    parameter int unsigned ABITS   = 16,
    parameter int unsigned DBITS   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    // Requester 0: Turing-machine engine
    input  logic             r0_ena,
    input  logic             r0_write,
    input  logic [ABITS-1:0] r0_addr,
    input  logic [DBITS-1:0] r0_wr_data,
    output logic             r0_ack,
    output logic             r0_busy,
    // Requester 1: tape scanner / debug reader
    input  logic             r1_ena,
    input  logic             r1_write,
    input  logic [ABITS-1:0] r1_addr,
    input  logic [DBITS-1:0] r1_wr_data,
    output logic             r1_ack,
    output logic             r1_busy,
    // Shared read data, forwarded unregistered
    output logic [DBITS-1:0] rd_data,
    // Memory side
    output logic             mem_ena,
    output logic             mem_write,
    output logic [ABITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wr_data,
    input  logic [DBITS-1:0] mem_rd_data,
    input  logic             mem_busy,
    input  logic             mem_ack,
    // Status
    output logic [31:0]      grant_cnt0,
    output logic [31:0]      grant_cnt1,
    output logic             timeout_err
);

    // The ISSUE counter only has to hold 0..TIMEOUT-1.
    localparam int unsigned   CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     gcnt0_q, gcnt0_d;
    logic [31:0]     gcnt1_q, gcnt1_d;
    logic            terr_q, terr_d;
    logic            sel_ena;

    // Memory request fields always follow the granted port.
    always_comb begin
        sel_ena     = grant_q ? r1_ena     : r0_ena;
        mem_write   = grant_q ? r1_write   : r0_write;
        mem_addr    = grant_q ? r1_addr    : r0_addr;
        mem_wr_data = grant_q ? r1_wr_data : r0_wr_data;
        rd_data     = mem_rd_data;
    end

    // Next-state, handshake and busy outputs.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        terr_d  = terr_q;
        mem_ena = 1'b0;
        r0_ack  = 1'b0;
        r1_ack  = 1'b0;
        r0_busy = mem_busy;
        r1_busy = mem_busy;

        // While a transaction owns the port the other requester must hold off.
        if (state_q != StIdle) begin
            r0_busy = grant_q ? 1'b1 : mem_busy;
            r1_busy = grant_q ? mem_busy : 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (r0_ena || r1_ena) begin
                    // On a tie the port that did not win last time goes first.
                    grant_d = (r0_ena && r1_ena) ? ~last_q : r1_ena;
                    last_d  = grant_d;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mem_ena = sel_ena;
                if (sel_ena && mem_ack) begin
                    // Ack beats a simultaneous timeout.
                    r0_ack  = ~grant_q;
                    r1_ack  = grant_q;
                    if (grant_q) gcnt1_d = gcnt1_q + 32'd1;
                    else         gcnt0_d = gcnt0_q + 32'd1;
                    state_d = mem_busy ? StWait : StIdle;
                end else if (!sel_ena) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (!mem_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            gcnt0_q <= '0;
            gcnt1_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
            terr_q  <= terr_d;
        end
    end

    assign grant_cnt0  = gcnt0_q;
    assign grant_cnt1  = gcnt1_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_tape_mem_arbiter.sv
// Bench for tape_mem_arbiter: directed timing scenarios plus randomized
// two-requester traffic over SRAM and DRAM memory models. Every ack is
// checked against a per-port scoreboard filled when the request is issued.
module tb_tape_mem_arbiter;

    logic        clk, rst;
    logic        r0_ena, r0_write, r0_ack, r0_busy;
    logic [15:0] r0_addr;
    logic [3:0]  r0_wr_data;
    logic        r1_ena, r1_write, r1_ack, r1_busy;
    logic [15:0] r1_addr;
    logic [3:0]  r1_wr_data;
    logic [3:0]  rd_data, mem_wr_data, mem_rd_data;
    logic        mem_ena, mem_write, mem_busy, mem_ack;
    logic [15:0] mem_addr;
    logic [31:0] grant_cnt0, grant_cnt1;
    logic        timeout_err;

    tape_mem_arbiter #(.ABITS(16), .DBITS(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .r0_ena(r0_ena), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wr_data(r0_wr_data),
        .r0_ack(r0_ack), .r0_busy(r0_busy),
        .r1_ena(r1_ena), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wr_data(r1_wr_data),
        .r1_ack(r1_ack), .r1_busy(r1_busy),
        .rd_data(rd_data),
        .mem_ena(mem_ena), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_busy(mem_busy), .mem_ack(mem_ack),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [3:0]  data;
        logic [3:0]  rdata;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    logic [3:0] ref_mem [65536];

    // Memory model: mode 0 = SRAM, 1 = DRAM, 2 = never acks.
    logic [3:0] mem [65536];
    int  mode = 2;
    int  ack_dly = 1;
    int  busy_len = 0;
    int  wcnt, busy_left, acc_cnt;
    logic force_busy = 1'b0;

    always_comb begin
        mem_ack  = 1'b0;
        mem_busy = force_busy;
        if (mode == 0) begin
            mem_ack = 1'b1;
        end else if (mode == 1) begin
            mem_ack  = mem_ena && (wcnt >= ack_dly - 1) && (busy_left == 0);
            mem_busy = force_busy || (busy_left > 0) || (mem_ack && busy_len > 0);
        end
        mem_rd_data = mem[mem_addr];
    end

    always @(posedge clk) begin
        if (rst) begin
            wcnt      <= 0;
            busy_left <= 0;
            acc_cnt   <= 0;
        end else if (mem_ena && mem_ack) begin
            if (mem_write) mem[mem_addr] <= mem_wr_data;
            acc_cnt   <= acc_cnt + 1;
            wcnt      <= 0;
            busy_left <= (mode == 1 && busy_len > 0) ? busy_len - 1 : 0;
        end else begin
            wcnt <= mem_ena ? wcnt + 1 : 0;
            if (busy_left > 0) busy_left <= busy_left - 1;
        end
    end

    function automatic logic [3:0] init_val(input int i);
        return 4'(i ^ (i >> 4) ^ (i >> 8) ^ 9);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Drive a request; the expected response comes from the reference memory.
    task automatic issue(input int p, input logic w, input logic [15:0] a, input logic [3:0] d,
                         input bit track);
        txn_t t;
        t.write = w;
        t.addr  = a;
        t.data  = d;
        t.rdata = ref_mem[a];
        if (w) ref_mem[a] = d;
        if (p == 0) begin
            r0_write = w; r0_addr = a; r0_wr_data = d; r0_ena = 1'b1;
            if (track) q0.push_back(t);
        end else begin
            r1_write = w; r1_addr = a; r1_wr_data = d; r1_ena = 1'b1;
            if (track) q1.push_back(t);
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) r0_ena = 1'b0;
        else        r1_ena = 1'b0;
    endtask

    // Starts and ends at a drive point; ena is dropped the cycle after the ack.
    task automatic wait_ack(input int p, input int max);
        bit got = 1'b0;
        for (int i = 0; i < max; i++) begin
            smp();
            if ((p == 0) ? r0_ack : r1_ack) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (got) tick();
        check($sformatf("r%0d_ack_wait", p), 32'(got), 32'd1);
        drop(p);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0_ena = 1'b0;
        r1_ena = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic requester(input int p, input int n);
        logic        pb;
        logic [15:0] a;
        pb = (p == 1);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            a = {pb, 11'd0, 4'($urandom)};
            issue(p, 1'($urandom_range(0, 1)), a, 4'($urandom), 1'b1);
            wait_ack(p, 100);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest pending request.
    task automatic mon_pop(input int p);
        txn_t e;
        int   sz;
        sz = (p == 0) ? q0.size() : q1.size();
        check($sformatf("r%0d_ack_has_pending", p), 32'(sz != 0), 32'd1);
        if (sz != 0) begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("r%0d_mem_ena_at_ack", p), 32'(mem_ena), 32'd1);
            check($sformatf("r%0d_addr", p), 32'(mem_addr), 32'(e.addr));
            check($sformatf("r%0d_write", p), 32'(mem_write), 32'(e.write));
            if (e.write) check($sformatf("r%0d_wdata", p), 32'(mem_wr_data), 32'(e.data));
            else         check($sformatf("r%0d_rdata", p), 32'(rd_data), 32'(e.rdata));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (r0_ack === 1'b1) mon_pop(0);
            if (r1_ack === 1'b1) mon_pop(1);
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic a0, a1;
        logic exp_next;
        rst = 1'b1;
        r0_ena = 1'b0; r0_write = 1'b1; r0_addr = 16'h1111; r0_wr_data = 4'h9;
        r1_ena = 1'b1; r1_write = 1'b0; r1_addr = 16'h2222; r1_wr_data = 4'h6;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     <= init_val(i);
            ref_mem[i]  = init_val(i);
        end
        mem[5]     <= 4'h3;
        ref_mem[5]  = 4'h3;

        // Reset state, with port 1 requesting to show nothing is granted.
        repeat (3) tick();
        smp();
        check("rst_mem_ena", 32'(mem_ena), 0);
        check("rst_acks", {30'd0, r1_ack, r0_ack}, 0);
        check("rst_cnt0", grant_cnt0, 0);
        check("rst_cnt1", grant_cnt1, 0);
        check("rst_terr", 32'(timeout_err), 0);
        check("rst_addr_port0", 32'(mem_addr), 32'h1111);
        check("rst_write_port0", 32'(mem_write), 1);
        check("rst_wdata_port0", 32'(mem_wr_data), 32'h9);
        check("rst_busy_low", {30'd0, r1_busy, r0_busy}, 0);
        tick();
        force_busy = 1'b1;
        smp();
        check("rst_busy_high", {30'd0, r1_busy, r0_busy}, 3);
        tick();
        force_busy = 1'b0;

        // Single port 0 read on SRAM: ack in the second cycle.
        mode = 0;
        do_reset();
        issue(0, 1'b0, 16'h0005, 4'h0, 1'b1);
        smp();
        check("t1_c1_mem_ena", 32'(mem_ena), 0);
        check("t1_c1_ack", 32'(r0_ack), 0);
        tick();
        smp();
        check("t1_c2_mem_ena", 32'(mem_ena), 1);
        check("t1_c2_ack", 32'(r0_ack), 1);
        check("t1_c2_rd_data", 32'(rd_data), 32'h3);
        tick();
        drop(0);
        smp();
        check("t1_c3_mem_ena", 32'(mem_ena), 0);
        check("t1_c3_ack", 32'(r0_ack), 0);
        check("t1_cnt0", grant_cnt0, 1);
        tick();

        // Both ports request continuously: alternate grants, ack every other cycle.
        do_reset();
        issue(0, 1'($urandom_range(0, 1)), {5'd0, 11'($urandom_range(0, 15))}, 4'($urandom), 1'b1);
        issue(1, 1'($urandom_range(0, 1)), {5'h10, 11'($urandom_range(0, 15))}, 4'($urandom), 1'b1);
        exp_next = 1'b0;
        for (int c = 0; c < 20; c++) begin
            smp();
            a0 = r0_ack;
            a1 = r1_ack;
            check($sformatf("t2_ack_cadence_c%0d", c), 32'(a0 | a1), 32'(c % 2));
            if (a0 || a1) begin
                check($sformatf("t2_alternate_c%0d", c), {30'd0, a1, a0},
                      exp_next ? 32'd2 : 32'd1);
                exp_next = ~exp_next;
            end
            tick();
            if (a0) issue(0, 1'($urandom_range(0, 1)), {5'd0, 11'($urandom_range(0, 15))},
                          4'($urandom), 1'b1);
            if (a1) issue(1, 1'($urandom_range(0, 1)), {5'h10, 11'($urandom_range(0, 15))},
                          4'($urandom), 1'b1);
        end
        smp();
        check("t2_cnt0", grant_cnt0, 5);
        check("t2_cnt1", grant_cnt1, 5);
        tick();

        // DRAM: port 1 write held through WAIT, port 0 waits with busy=1.
        do_reset();
        mode = 1; ack_dly = 3; busy_len = 4;
        issue(1, 1'b1, 16'h1234, 4'hA, 1'b1);
        for (int c = 0; c < 10; c++) begin
            smp();
            check($sformatf("t3_mem_ena_c%0d", c), 32'(mem_ena),
                  32'((c >= 1 && c <= 3) || c == 9));
            check($sformatf("t3_r0_busy_c%0d", c), 32'(r0_busy), 32'(c >= 1 && c <= 7));
            check($sformatf("t3_r1_ack_c%0d", c), 32'(r1_ack), 32'(c == 3));
            if (c == 9) check("t3_port0_write", 32'(mem_write), 0);
            tick();
            if (c == 0) issue(0, 1'b0, 16'h1234, 4'h0, 1'b1);
            if (c == 3) drop(1);
        end
        wait_ack(0, 20);
        repeat (8) tick();
        smp();
        check("t3_cnt0", grant_cnt0, 1);
        check("t3_cnt1", grant_cnt1, 1);
        tick();

        // Memory never acks: abort after 8 ISSUE cycles, then serve port 1.
        do_reset();
        mode = 2;
        issue(0, 1'b0, 16'h0042, 4'h0, 1'b0);
        for (int c = 0; c < 9; c++) begin
            smp();
            check($sformatf("t4_mem_ena_c%0d", c), 32'(mem_ena), 32'(c >= 1));
            check($sformatf("t4_terr_c%0d", c), 32'(timeout_err), 0);
            tick();
        end
        drop(0);
        mode = 0;
        issue(1, 1'b0, 16'h8003, 4'h0, 1'b1);
        smp();
        check("t4_abort_mem_ena", 32'(mem_ena), 0);
        check("t4_terr_set", 32'(timeout_err), 1);
        tick();
        wait_ack(1, 10);
        smp();
        check("t4_terr_sticky", 32'(timeout_err), 1);
        check("t4_cnt0", grant_cnt0, 0);
        check("t4_cnt1", grant_cnt1, 1);
        tick();

        // Port 0 withdraws in ISSUE; pending port 1 is granted next.
        do_reset();
        mode = 1; ack_dly = 3; busy_len = 2;
        issue(0, 1'b0, 16'h0011, 4'h0, 1'b0);
        issue(1, 1'b0, 16'h8011, 4'h0, 1'b1);
        smp();
        check("t5_c0_mem_ena", 32'(mem_ena), 0);
        tick();
        smp();
        check("t5_c1_mem_ena", 32'(mem_ena), 1);
        check("t5_c1_addr", 32'(mem_addr), 32'h0011);
        tick();
        drop(0);
        smp();
        check("t5_c2_mem_ena", 32'(mem_ena), 0);
        check("t5_c2_ack", 32'(r0_ack), 0);
        tick();
        smp();
        check("t5_c3_idle_mem_ena", 32'(mem_ena), 0);
        tick();
        smp();
        check("t5_c4_mem_ena", 32'(mem_ena), 1);
        check("t5_c4_addr", 32'(mem_addr), 32'h8011);
        tick();
        wait_ack(1, 20);
        repeat (4) tick();
        smp();
        check("t5_cnt0", grant_cnt0, 0);
        check("t5_cnt1", grant_cnt1, 1);
        check("t5_terr", 32'(timeout_err), 0);
        tick();

        // Reset during WAIT abandons the op; port 0 wins the next tie.
        do_reset();
        mode = 1; ack_dly = 1; busy_len = 6;
        issue(1, 1'b1, 16'h8020, 4'h7, 1'b1);
        smp();
        check("t6_c0_mem_ena", 32'(mem_ena), 0);
        tick();
        smp();
        check("t6_c1_ack", 32'(r1_ack), 1);
        tick();
        drop(1);
        smp();
        check("t6_wait_mem_ena", 32'(mem_ena), 0);
        check("t6_wait_r0_busy", 32'(r0_busy), 1);
        check("t6_wait_cnt1", grant_cnt1, 1);
        tick();
        rst = 1'b1;
        smp();
        tick();
        rst = 1'b0;
        mode = 0;
        issue(0, 1'b0, 16'h0020, 4'h0, 1'b1);
        issue(1, 1'b0, 16'h8020, 4'h0, 1'b1);
        smp();
        check("t6_post_mem_ena", 32'(mem_ena), 0);
        check("t6_post_cnt0", grant_cnt0, 0);
        check("t6_post_cnt1", grant_cnt1, 0);
        check("t6_post_busy", {30'd0, r1_busy, r0_busy}, 0);
        tick();
        smp();
        check("t6_tie_mem_ena", 32'(mem_ena), 1);
        check("t6_tie_addr", 32'(mem_addr), 32'h0020);
        check("t6_tie_ack0", 32'(r0_ack), 1);
        tick();
        drop(0);
        wait_ack(1, 10);
        smp();
        check("t6_cnt0", grant_cnt0, 1);
        check("t6_cnt1", grant_cnt1, 1);
        tick();

        // Randomized traffic: SRAM round, then DRAM round with random latency.
        for (int round = 0; round < 2; round++) begin
            do_reset();
            mode = (round == 0) ? 0 : 1;
            ack_dly = $urandom_range(1, 4);
            busy_len = $urandom_range(0, 3);
            fork
                requester(0, 40);
                requester(1, 40);
            join
            repeat (6) tick();
            smp();
            check($sformatf("rnd%0d_cnt0", round), grant_cnt0, 40);
            check($sformatf("rnd%0d_cnt1", round), grant_cnt1, 40);
            check($sformatf("rnd%0d_mem_accesses", round), 32'(acc_cnt), 80);
            check($sformatf("rnd%0d_queues_empty", round), 32'(q0.size() + q1.size()), 0);
            check($sformatf("rnd%0d_terr", round), 32'(timeout_err), 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
